imem_responder: RTL and testbench

//  Instruction-memory responder: the memory side of the fetch path. Accepts a
//  64-bit fetch address from the IFU over a valid/ready request channel. After
//  a programmable latency, returns the 32-bit instruction word over a

---
 rtl/imem_responder_pkg.sv | 24 ++
 rtl/imem_responder_if.sv | 23 ++
 rtl/imem_responder_array.sv | 38 +++
 rtl/imem_responder.sv | 125 ++++++++++++
 tb/tb_imem_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: bus widths,
// FSM state encodings, default base address and the access-fault check.
package imem_responder_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 64'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Fault when the PC is not word aligned or the offset from the base
    // (already wrapped modulo 2^64) falls outside the store.
    function automatic logic addr_fault(input logic [1:0]        lsb,
                                        input logic [ADDR_W-1:0] offset,
                                        input logic [ADDR_W-1:0] span);
        return (lsb != 2'b00) || (offset >= span);
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response channels between the IFU (master) and the
// instruction-memory responder (slave).
interface imem_responder_if;

    logic                                   req_valid;
    logic                                   req_ready;
    logic [imem_responder_pkg::ADDR_W-1:0]  req_addr;
    logic                                   resp_valid;
    logic                                   resp_ready;
    logic [imem_responder_pkg::INSTR_W-1:0] resp_instr;
    logic                                   resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_err
    );

endinterface

// File: rtl/imem_responder_array.sv
// DEPTH x 32 instruction store: one write port and one synchronous,
// read-before-write read port whose output register holds between reads.
module imem_array #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ren,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata,
    input  logic             wen,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            r_mem[widx] <= wdata;
        end
    end

    // Registered read; a same-edge write to ridx lands after this sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (ren) begin
            r_rdata <= r_mem[ridx];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, waits the
// programmed latency, then returns the instruction word or an access fault.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    imem_responder_if.slave          bus,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [31:0]              ld_data
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam int                CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH) << 2;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic                r_resp_err;

    logic                w_accept;
    logic [ADDR_W-1:0]   w_chk_addr;
    logic [ADDR_W-1:0]   w_offset;
    logic                w_err;
    logic                w_enter_resp;
    logic                w_ren;
    logic [IDX_W-1:0]    w_ridx;
    logic [31:0]         w_rdata;

    // req_ready is only ever high in IDLE, so it alone qualifies acceptance.
    assign w_accept = bus.req_valid & r_req_ready;

    // With LATENCY==1 the check runs on the live address of the accepting edge.
    assign w_chk_addr = (r_state == S_IDLE) ? bus.req_addr : r_addr;
    assign w_offset   = w_chk_addr - BASE_ADDR;
    assign w_err      = addr_fault(w_chk_addr[1:0], w_offset, SPAN);
    assign w_ridx     = IDX_W'(w_offset >> 2);

    // The WAIT exit fires as the counter steps from 1 to 0.
    assign w_enter_resp = ((LATENCY == 1) && (r_state == S_IDLE) && w_accept) ||
                          ((r_state == S_WAIT) && (r_cnt == CNT_W'(1)));
    assign w_ren        = w_enter_resp & ~w_err;

    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .ren   (w_ren),
        .ridx  (w_ridx),
        .rdata (w_rdata),
        .wen   (ld_en),
        .widx  (ld_idx),
        .wdata (ld_data)
    );

    // Latch the fetch address on acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= bus.req_addr;
        end
    end

    // Request/response FSM with latency counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_err;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_enter_resp) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_instr = r_resp_err ? 32'h0 : w_rdata;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance at LATENCY=1 and one at
// LATENCY=3 share a clock; expected words and timings are written by hand.
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int DEPTH = 4096;
    localparam int IDX_W = 12;

    logic clk = 1'b0;
    logic rst0_n;
    logic rst1_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;

    // Index 0 drives the LATENCY=1 instance, index 1 the LATENCY=3 instance.
    logic             req_valid  [2];
    logic [63:0]      req_addr   [2];
    logic             resp_ready [2];
    logic             ld_en      [2];
    logic [IDX_W-1:0] ld_idx     [2];
    logic [31:0]      ld_data    [2];
    logic             o_req_ready  [2];
    logic             o_resp_valid [2];
    logic [31:0]      o_resp_instr [2];
    logic             o_resp_err   [2];

    imem_responder_if bus0 ();
    imem_responder_if bus1 ();

    assign bus0.req_valid  = req_valid[0];
    assign bus0.req_addr   = req_addr[0];
    assign bus0.resp_ready = resp_ready[0];
    assign bus1.req_valid  = req_valid[1];
    assign bus1.req_addr   = req_addr[1];
    assign bus1.resp_ready = resp_ready[1];

    assign o_req_ready[0]  = bus0.req_ready;
    assign o_resp_valid[0] = bus0.resp_valid;
    assign o_resp_instr[0] = bus0.resp_instr;
    assign o_resp_err[0]   = bus0.resp_err;
    assign o_req_ready[1]  = bus1.req_ready;
    assign o_resp_valid[1] = bus1.resp_valid;
    assign o_resp_instr[1] = bus1.resp_instr;
    assign o_resp_err[1]   = bus1.resp_err;

    imem_responder #(
        .BASE_ADDR (DEF_BASE_ADDR),
        .DEPTH     (DEPTH),
        .LATENCY   (1)
    ) u_dut_l1 (
        .clk     (clk),
        .rst_n   (rst0_n),
        .bus     (bus0),
        .ld_en   (ld_en[0]),
        .ld_idx  (ld_idx[0]),
        .ld_data (ld_data[0])
    );

    imem_responder #(
        .BASE_ADDR (DEF_BASE_ADDR),
        .DEPTH     (DEPTH),
        .LATENCY   (3)
    ) u_dut_l3 (
        .clk     (clk),
        .rst_n   (rst1_n),
        .bus     (bus1),
        .ld_en   (ld_en[1]),
        .ld_idx  (ld_idx[1]),
        .ld_data (ld_data[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int s, input int idx, input logic [31:0] data);
        ld_en[s]   = 1'b1;
        ld_idx[s]  = IDX_W'(idx);
        ld_data[s] = data;
        step();
        ld_en[s] = 1'b0;
    endtask

    // One complete fetch with resp_ready held high; checks latency, data,
    // fault flag and the return to an accepting state after the handshake.
    task automatic fetch(input int s, input logic [63:0] a, input logic [31:0] ei,
                         input logic ee, input int lat, input string tag,
                         output int t_resp);
        int n;
        chk({tag, ".req_ready"}, 64'(o_req_ready[s]), 64'd1);
        req_valid[s]  = 1'b1;
        req_addr[s]   = a;
        resp_ready[s] = 1'b1;
        step();
        req_valid[s] = 1'b0;
        n = 1;
        while (!o_resp_valid[s] && n < 20) begin
            step();
            n++;
        end
        t_resp = cyc;
        chk({tag, ".latency"}, 64'(n), 64'(lat));
        chk({tag, ".instr"}, 64'(o_resp_instr[s]), 64'(ei));
        chk({tag, ".err"}, 64'(o_resp_err[s]), 64'(ee));
        step();
        chk({tag, ".valid_drop"}, 64'(o_resp_valid[s]), 64'd0);
        chk({tag, ".ready_back"}, 64'(o_req_ready[s]), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t_prev;
        logic [31:0] held;
        for (int s = 0; s < 2; s++) begin
            req_valid[s]  = 1'b0;
            req_addr[s]   = '0;
            resp_ready[s] = 1'b0;
            ld_en[s]      = 1'b0;
            ld_idx[s]     = '0;
            ld_data[s]    = '0;
        end
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        #1;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        #2;
        for (int s = 0; s < 2; s++) begin
            chk("rst.req_ready", 64'(o_req_ready[s]), 64'd1);
            chk("rst.resp_valid", 64'(o_resp_valid[s]), 64'd0);
            chk("rst.resp_instr", 64'(o_resp_instr[s]), 64'd0);
            chk("rst.resp_err", 64'(o_resp_err[s]), 64'd0);
        end
        step();
        step();
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        step();

        // Image for the LATENCY=1 instance.
        load(0, 0, 32'h0000_0413);
        load(0, 5, 32'h1111_2222);
        load(0, 4095, 32'hCAFE_F00D);
        for (int i = 0; i < 8; i++) load(0, 8 + i, 32'h1000_0000 + 32'(i));
        // Image for the LATENCY=3 instance.
        load(1, 1, 32'h1234_5678);
        load(1, 2, 32'hA5A5_0002);

        // Basic single-cycle-latency fetch.
        fetch(0, 64'h8000_0000, 32'h0000_0413, 1'b0, 1, "t1", t);

        // LATENCY=3 with the consumer stalling for four cycles.
        chk("t2.req_ready0", 64'(o_req_ready[1]), 64'd1);
        req_valid[1]  = 1'b1;
        req_addr[1]   = 64'h8000_0004;
        resp_ready[1] = 1'b0;
        step();
        req_valid[1] = 1'b0;
        chk("t2.wait1_valid", 64'(o_resp_valid[1]), 64'd0);
        chk("t2.wait1_ready", 64'(o_req_ready[1]), 64'd0);
        step();
        chk("t2.wait2_valid", 64'(o_resp_valid[1]), 64'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("t2.hold_valid", 64'(o_resp_valid[1]), 64'd1);
            chk("t2.hold_instr", 64'(o_resp_instr[1]), 64'h1234_5678);
            chk("t2.hold_ready", 64'(o_req_ready[1]), 64'd0);
            if (k < 3) step();
        end
        resp_ready[1] = 1'b1;
        step();
        chk("t2.post_valid", 64'(o_resp_valid[1]), 64'd0);
        chk("t2.post_ready", 64'(o_req_ready[1]), 64'd1);
        chk("t2.post_instr_held", 64'(o_resp_instr[1]), 64'h1234_5678);

        // Access faults and the last in-range word.
        fetch(0, 64'h8000_0002, 32'h0, 1'b1, 1, "t3.misalign", t);
        fetch(0, 64'h7FFF_FFFC, 32'h0, 1'b1, 1, "t3.below", t);
        fetch(0, 64'h8000_4000, 32'h0, 1'b1, 1, "t3.above", t);
        fetch(0, 64'h8000_3FFC, 32'hCAFE_F00D, 1'b0, 1, "t3.last", t);

        // Side-load on the RESP-entry edge of the same word returns old data.
        ld_en[0]   = 1'b1;
        ld_idx[0]  = IDX_W'(5);
        ld_data[0] = 32'hDEAD_BEEF;
        fetch(0, 64'h8000_0014, 32'h1111_2222, 1'b0, 1, "t4.old", t);
        ld_en[0] = 1'b0;
        fetch(0, 64'h8000_0014, 32'hDEAD_BEEF, 1'b0, 1, "t4.new", t);

        // Reset while the LATENCY=3 instance is in WAIT.
        req_valid[1]  = 1'b1;
        req_addr[1]   = 64'h8000_0008;
        resp_ready[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        step();
        rst1_n = 1'b0;
        #1;
        chk("t5.rst_valid", 64'(o_resp_valid[1]), 64'd0);
        chk("t5.rst_ready", 64'(o_req_ready[1]), 64'd1);
        step();
        step();
        rst1_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5.no_stale", 64'(o_resp_valid[1]), 64'd0);
        end
        fetch(1, 64'h8000_0008, 32'hA5A5_0002, 1'b0, 3, "t5.mem_kept", t);

        // Back-to-back sequential fetches: one response every LATENCY+1 cycles.
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            fetch(0, 64'h8000_0020 + 64'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 1, "t6.seq", t);
            if (i > 0) chk("t6.spacing", 64'(t - t_prev), 64'd2);
            t_prev = t;
        end
        held = o_resp_instr[0];
        chk("t6.idle_hold", 64'(held), 64'h1000_0007);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
